mem_initiator: RTL and testbench
================================

// Module: mem_initiator
//
// PURPOSE
//  Requesting end of the physical-memory port: takes one read/write request at a time
//  from the CPU side and drives the synchronous memory responder (mem_addr, mem_read,
//  mem_write strobes; read_ack/write_ack/nxm returns). Holds address and data stable,
//  waits for the acknowledge, times out missing memory as NXM, and returns one response.
//  Sits between the KV10 CPU/pager and the memory, cache or bus arbiter.
//
// PARAMETERS
//  TIMEOUT  15  cycles to wait for an ack, counted from the first WAIT cycle;
//               expiry reports NXM; 0 = never time out
//
// PORTS
//  clk             in   1          clock; all logic on posedge
//  reset           in   1          synchronous reset, ACTIVE-LOW (0 = reset)
//  req_valid       in   1          CPU request present
//  req_ready       out  1          1 only in IDLE; request accepted when valid & ready
//  req_write       in   1          1 = write, 0 = read
//  req_addr        in   `PADDR     physical address
//  req_wdata       in   `WORD      write data
//  resp_valid      out  1          one-cycle response pulse
//  resp_rdata      out  `WORD      read data, valid with resp_valid
//  resp_nxm        out  1          non-existent memory, valid with resp_valid
//  err_stray       out  1          sticky: ack/nxm seen outside WAIT; cleared only by reset
//  mem_addr        out  `PADDR     to responder; held stable REQ..WAIT
//  mem_write_data  out  `WORD      to responder; held stable REQ..WAIT
//  mem_read        out  1          one-cycle read strobe
//  mem_write       out  1          one-cycle write strobe
//  mem_read_data   in   `WORD      from responder, sampled with read_ack
//  read_ack        in   1          read complete
//  write_ack       in   1          write complete
//  nxm             in   1          responder reports no memory at mem_addr
//
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state IDLE; all outputs 0, counter 0; any request in
//    flight is dropped with no response.
//  - Registered outputs only; no combinational path from inputs to outputs.
//  - FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid, latch req_write/req_addr/req_wdata into
//    mem_addr/mem_write_data; go to REQ.
//  - REQ: exactly one cycle. mem_read=!write or mem_write=write; never both. Acks seen
//    in REQ are ignored and set err_stray. Go to WAIT; the timeout counter clears.
//  - WAIT: strobes 0. At each posedge check, in priority order:
//    nxm=1 -> RESP with resp_nxm=1, resp_rdata=0;
//    matching ack (read_ack for read, write_ack for write) -> RESP; on read latch
//    mem_read_data into resp_rdata; on write resp_rdata=0;
//    counter==TIMEOUT-1 (TIMEOUT!=0) -> RESP with resp_nxm=1, resp_rdata=0;
//    otherwise counter+1. A non-matching ack is ignored and sets err_stray.
//  - RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_nxm keep
//    their values until the next RESP.
//  - Counter width is $clog2(TIMEOUT+1); it cannot wrap.
//  - Latency with a zero-wait responder: accept@edge0, strobe in cycle 1, ack in
//    cycle 2, resp_valid in cycle 3, req_ready in cycle 4. Throughput is one request
//    per 4 cycles.
//  - An ack/nxm arriving in IDLE or RESP (a late ack after timeout) is discarded and
//    sets err_stray; the FSM is unaffected.
//
// TESTING
//  1. Read 0o1000 holding 0o123456654321 (zero-wait): mem_read high exactly 1 cycle,
//     resp_valid 3 cycles after accept, resp_rdata=0o123456654321, resp_nxm=0.
//  2. Write 0o777777000000 to 0o2000, then read it back: one mem_write pulse, write
//     resp has rdata 0, read returns 0o777777000000; mem_addr stable throughout.
//  3. Responder acks 5 cycles after strobe, TIMEOUT=15: resp_valid with no NXM;
//     a read_ack during a write WAIT is ignored and err_stray=1.
//  4. No ack, TIMEOUT=15: resp_valid with resp_nxm=1 exactly 16 cycles after the strobe;
//     a late read_ack 3 cycles later sets err_stray and produces no second resp_valid.
//  5. Responder raises nxm on the first WAIT cycle: resp_nxm=1, resp_rdata=0,
//     then req_ready=1.
//  6. reset=0 for 1 cycle during WAIT: all outputs 0 next cycle, no resp_valid,
//     err_stray=0; a subsequent read completes normally.

Source files
------------

// File: rtl/mem_initiator.sv
// ---------------------------------------------------------------------------
// mem_initiator
//
// Requesting end of the physical-memory port. Accepts one CPU read/write
// request at a time, presents it to a synchronous memory responder with a
// one-cycle strobe, holds address/data stable until the transfer ends, waits
// for the matching acknowledge (or NXM, or a timeout) and returns exactly one
// one-cycle response.
//
// Handshake (both sides): a request transfers on the posedge where
// req_valid && req_ready are both 1. req_ready is 1 only while idle. The
// response side has no back-pressure: resp_valid is a one-cycle pulse and
// resp_rdata/resp_nxm stay valid until the next response.
//
// Ports
//   clk, reset         clock (posedge) / synchronous active-low reset
//   req_valid/ready    CPU request handshake
//   req_write          1 = write, 0 = read
//   req_addr/wdata     request address and write data
//   resp_valid         one-cycle response pulse
//   resp_rdata/nxm     response read data and non-existent-memory flag
//   err_stray          sticky: ack/nxm seen when none was expected
//   mem_addr/write_data address and data to the responder
//   mem_read/write     one-cycle strobes to the responder
//   mem_read_data      read data from the responder, taken with read_ack
//   read_ack/write_ack completion from the responder
//   nxm                responder reports no memory at mem_addr
//   dbg_state          current FSM state, for observation only
// ---------------------------------------------------------------------------
module mem_initiator #(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 22,
  parameter int DATA_W  = 36
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_nxm,
  output logic              err_stray,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              read_ack,
  input  logic              write_ack,
  input  logic              nxm,
  output logic [1:0]        dbg_state
);

  // A zero TIMEOUT disables the timeout; keep the counter at least 1 bit wide.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           state;
  logic             is_write;
  logic [CNT_W-1:0] cnt;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      is_write       <= 1'b0;
      cnt            <= '0;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_nxm       <= 1'b0;
      err_stray      <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
    end else begin
      // Strobes and the response pulse last one cycle unless re-asserted.
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            state          <= S_REQ;
            req_ready      <= 1'b0;
            is_write       <= req_write;
            mem_addr       <= req_addr;
            mem_write_data <= req_wdata;
            // Strobe is issued together with entering REQ so that it is
            // visible for exactly the REQ cycle.
            mem_read       <= !req_write;
            mem_write      <= req_write;
          end else begin
            // Covers the first idle cycle after reset, where ready is still 0.
            req_ready <= 1'b1;
          end
          if (read_ack || write_ack || nxm) err_stray <= 1'b1;
        end

        S_REQ: begin
          state <= S_WAIT;
          cnt   <= '0;
          // The responder cannot legitimately answer in the strobe cycle.
          if (read_ack || write_ack || nxm) err_stray <= 1'b1;
        end

        S_WAIT: begin
          if (nxm) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_nxm   <= 1'b1;
            resp_rdata <= '0;
          end else if (is_write ? write_ack : read_ack) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_nxm   <= 1'b0;
            resp_rdata <= is_write ? '0 : mem_read_data;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_nxm   <= 1'b1;
            resp_rdata <= '0;
          end else if (TIMEOUT != 0) begin
            // Exits at TO_LAST, so the counter never wraps.
            cnt <= cnt + 1'b1;
          end
          if (is_write ? read_ack : write_ack) err_stray <= 1'b1;
        end

        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          // Typically a late ack from a responder we already timed out.
          if (read_ack || write_ack || nxm) err_stray <= 1'b1;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// ---------------------------------------------------------------------------
// tb_mem_initiator
//
// Bench for mem_initiator. A responder and a sparse memory model live in the
// bench; each transaction's expected response cycle, data and NXM flag are
// computed from the transfer rules (ack cycle vs timeout window) with plain
// arithmetic. Inputs change and outputs are sampled on the falling edge.
// Cycle numbering inside a transaction: cycle 1 is the cycle after the
// accepting posedge.
// ---------------------------------------------------------------------------
module tb_mem_initiator;

  localparam int TIMEOUT = 15;
  localparam int AW      = 22;
  localparam int DW      = 36;

  localparam int M_ACK    = 0;
  localparam int M_NXM    = 1;
  localparam int M_SILENT = 2;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_nxm;
  logic          err_stray;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_write_data;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_read_data;
  logic          read_ack;
  logic          write_ack;
  logic          nxm;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_model [logic [AW-1:0]];

  mem_initiator #(.TIMEOUT(TIMEOUT), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_nxm      (resp_nxm),
    .err_stray     (err_stray),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_read_data (mem_read_data),
    .read_ack      (read_ack),
    .write_ack     (write_ack),
    .nxm           (nxm),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return '0;
  endfunction

  task automatic clear_resp_inputs();
    read_ack      = 1'b0;
    write_ack     = 1'b0;
    nxm           = 1'b0;
    mem_read_data = rnd_word();
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_req", req_ready, 1'b1);
  endtask

  // One complete transaction. d = extra cycles before the responder answers
  // (answer lands in cycle 2+d), mode selects ack / nxm / no answer, stray
  // adds a wrong-type ack in the first WAIT cycle.
  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int d, input int mode, input bit stray, input string tag);
    int            r_cyc;
    int            exp_r;
    int            rd_pulses;
    int            wr_pulses;
    bit            addr_bad;
    bit            data_bad;
    bit            answers;
    bit            exp_nxm;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] rd_value;

    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = $urandom_range(0, 1);
    req_addr  = AW'($urandom);
    req_wdata = rnd_word();

    // Reference: an answer counts only if it falls within the TIMEOUT WAIT
    // cycles (cycles 2 .. TIMEOUT+1); the response follows one cycle later,
    // otherwise the timeout response appears in cycle TIMEOUT+2.
    rd_value = model_read(a);
    answers  = (mode != M_SILENT) && (d < TIMEOUT);
    exp_r    = answers ? 3 + d : TIMEOUT + 2;
    exp_nxm  = !answers || (mode == M_NXM);
    exp_data = (exp_nxm || wr) ? '0 : rd_value;
    if (wr && !exp_nxm) mem_model[a] = wd;

    r_cyc = -1; rd_pulses = 0; wr_pulses = 0; addr_bad = 0; data_bad = 0;
    for (int cyc = 1; cyc <= 40 && r_cyc < 0; cyc++) begin
      rd_pulses += int'(mem_read);
      wr_pulses += int'(mem_write);
      if (mem_addr !== a) addr_bad = 1;
      if (wr && mem_write_data !== wd) data_bad = 1;
      if (resp_valid === 1'b1) begin
        r_cyc = cyc;
      end else begin
        clear_resp_inputs();
        if (cyc == 2 + d) begin
          if (mode == M_NXM) nxm = 1'b1;
          else if (mode == M_ACK) begin
            if (wr) write_ack = 1'b1;
            else begin
              read_ack      = 1'b1;
              mem_read_data = rd_value;
            end
          end
        end
        if (stray && cyc == 2) read_ack = 1'b1;
        @(negedge clk);
      end
    end
    clear_resp_inputs();

    chk({tag, "_resp_cycle"}, 64'(r_cyc), 64'(exp_r));
    chk({tag, "_rdata"}, resp_rdata, exp_data);
    chk({tag, "_nxm"}, resp_nxm, exp_nxm);
    chk({tag, "_rd_strobes"}, 64'(rd_pulses), 64'(wr ? 0 : 1));
    chk({tag, "_wr_strobes"}, 64'(wr_pulses), 64'(wr ? 1 : 0));
    chk({tag, "_addr_stable"}, addr_bad, 1'b0);
    chk({tag, "_wdata_stable"}, data_bad, 1'b0);

    @(negedge clk);
    chk({tag, "_pulse_len"}, resp_valid, 1'b0);
    chk({tag, "_ready_after"}, req_ready, 1'b1);
    chk({tag, "_rdata_held"}, resp_rdata, exp_data);
    chk({tag, "_nxm_held"}, resp_nxm, exp_nxm);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int extra;
    logic [AW-1:0] addrs [4];
    addrs[0] = AW'('o1000); addrs[1] = AW'('o2000); addrs[2] = AW'('o3000); addrs[3] = AW'('o4000);

    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clear_resp_inputs();
    mem_model[AW'('o1000)] = DW'(36'o123456654321);

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, '0);
    chk("rst_resp_nxm", resp_nxm, 1'b0);
    chk("rst_err_stray", err_stray, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_write_data, '0);
    chk("rst_strobes", {mem_read, mem_write}, 2'b00);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_ready", req_ready, 1'b1);

    // zero-wait read of preloaded word
    do_txn(0, AW'('o1000), '0, 0, M_ACK, 0, "t1_read");
    chk("t1_data_value", resp_rdata, DW'(36'o123456654321));

    // write then read back
    do_txn(1, AW'('o2000), DW'(36'o777777000000), 0, M_ACK, 0, "t2_write");
    do_txn(0, AW'('o2000), '0, 0, M_ACK, 0, "t2_read");
    chk("t2_readback", resp_rdata, DW'(36'o777777000000));
    chk("t2_no_stray", err_stray, 1'b0);

    // nxm on first WAIT cycle
    do_txn(0, AW'('o3000), '0, 0, M_NXM, 0, "t5_nxm");
    chk("t5_no_stray", err_stray, 1'b0);

    // slow responder with a wrong-type ack during a write
    do_txn(1, AW'('o4000), DW'(36'o525252525252), 4, M_ACK, 1, "t3_slow_write");
    chk("t3_err_stray", err_stray, 1'b1);
    do_txn(0, AW'('o4000), '0, 4, M_ACK, 0, "t3_slow_read");

    // reset pulse in the middle of WAIT
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'('o1000); req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t6_req_ready", req_ready, 1'b0);
    chk("t6_resp_valid", resp_valid, 1'b0);
    chk("t6_resp_rdata", resp_rdata, '0);
    chk("t6_resp_nxm", resp_nxm, 1'b0);
    chk("t6_err_stray", err_stray, 1'b0);
    chk("t6_mem_addr", mem_addr, '0);
    chk("t6_strobes", {mem_read, mem_write}, 2'b00);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      extra += int'(resp_valid);
    end
    chk("t6_no_resp", 64'(extra), 64'(0));
    do_txn(0, AW'('o1000), '0, 0, M_ACK, 0, "t6_after");

    // randomized transactions
    for (int n = 0; n < 25; n++) begin
      int mode;
      int pick;
      pick = $urandom_range(0, 9);
      mode = (pick == 0) ? M_NXM : (pick == 1) ? M_SILENT : M_ACK;
      do_txn(bit'($urandom_range(0, 1)), addrs[$urandom_range(0, 3)], rnd_word(),
             $urandom_range(0, 18), mode, 0, "rnd");
    end
    chk("rnd_no_stray", err_stray, 1'b0);

    // timeout, then a late ack
    do_txn(0, AW'('o2000), '0, 30, M_SILENT, 0, "t4_timeout");
    @(negedge clk);
    @(negedge clk);
    read_ack = 1'b1;
    @(negedge clk);
    read_ack = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      extra += int'(resp_valid);
    end
    chk("t4_late_stray", err_stray, 1'b1);
    chk("t4_no_second_resp", 64'(extra), 64'(0));
    chk("t4_ready", req_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
